lane_arbiter: RTL
=================

LANE_ARBITER -- requirements
Module: lane_arbiter

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset, with ports as listed below.
REQ-002 clk_1  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk_1.
REQ-004 dataIn0..dataIn3  input  8 each  byte offered by lane 0..3.
REQ-005 validIn0..validIn3  input  1 each  dataInN is valid this cycle.
REQ-006 pause  input  1  downstream stall; no word is issued while high.
REQ-007 dataOut  output  8  granted byte, registered.
REQ-008 validOut  output  1  dataOut holds a new word this cycle, registered.
REQ-009 grant  output  2  index of the lane that sourced dataOut, registered.
REQ-010 full0..full3  output  1 each  lane N FIFO holds 4 words (combinational from the lane count).
REQ-011 err0..err3  output  1 each  sticky overflow flag for lane N, registered.

Function
REQ-012 Each lane SHALL own a 4-entry FIFO, 8 bits wide, with a 3-bit occupancy count (0..4) and 2-bit wrapping read and write pointers.
REQ-013 Push SHALL occur when validInN=1 and either countN<4 or lane N is popped in the same cycle.
REQ-014 When validInN=1, countN=4 and lane N is not popped, the word SHALL be discarded, errN SHALL be set, and FIFO state SHALL be unchanged.
REQ-015 errN SHALL stay at 1 until reset.
REQ-016 The block SHALL keep a 2-bit pointer last holding the most recently granted lane.
REQ-017 Each cycle with pause=0, the arbiter SHALL choose the first non-empty lane in the order last+1, last+2, last+3, last+4 (all mod 4), using pre-edge counts.
REQ-018 On a chosen lane the block SHALL: pop its head word into dataOut, set validOut=1, set grant to the lane index, and set last to the lane index, all at that edge.
REQ-019 If no lane is non-empty and pause=0, the block SHALL set validOut=0 and hold dataOut, grant and last.
REQ-020 When pause=1, the block SHALL perform no pop, set validOut=0, and hold dataOut, grant and last; pushes SHALL continue normally.
REQ-021 Latency: a word pushed at edge N SHALL appear on dataOut no earlier than edge N+1.
REQ-022 An empty lane SHALL never be granted.
REQ-023 Within a lane, words SHALL leave in arrival order.
REQ-024 With all 4 lanes continuously non-empty and pause=0, grants SHALL follow the strict cycle 0,1,2,3,0,...; each lane receives exactly 1 of every 4 issue slots.
REQ-025 Push and pop on the same lane in the same edge SHALL leave countN unchanged.
REQ-026 full0..full3 SHALL be asserted exactly when countN=4.

Reset
REQ-027 With reset=1 at an edge, all FIFOs SHALL become empty (counts and pointers 0).
REQ-028 With reset=1 at an edge, last SHALL be set to 3, so lane 0 has first priority.
REQ-029 With reset=1 at an edge, the registered outputs SHALL become dataOut=8'h00, validOut=0, grant=0 and err0..3=0; full0..3 SHALL read 0 because all counts are 0.
REQ-030 While reset=1, validInN and pause SHALL be ignored; no push or pop occurs.
REQ-031 A reset asserted mid-operation SHALL discard all buffered words; no stale word SHALL appear after reset is released.

Verification
REQ-032 Scenario, round-robin: after reset, one edge pushes FF/EE/DD/CC on lanes 0..3 -> the next four edges give dataOut FF,EE,DD,CC with grant 0,1,2,3 and validOut=1; the following edge gives validOut=0.
REQ-033 Scenario, single lane: only lane 2 is valid with 77 for 3 cycles -> dataOut=77 with grant=2 on three consecutive cycles, starting one edge after the first push; no other grant occurs.
REQ-034 Scenario, overflow: pause=1, lane 1 pushes BB,AA,99,88,77 -> full1=1 after the 4th push and err1=1 after the 5th; after pause is released, output is BB,AA,99,88 only (77 is lost).
REQ-035 Scenario, pause hold: with a stream in progress, pause=1 for 3 cycles -> validOut=0 and dataOut/grant held during the pause; the stream resumes with the next lane in round-robin order and no word is skipped or duplicated.
REQ-036 Scenario, reset mid-operation: with all lanes holding 2 words, reset=1 for 1 cycle -> all outputs take their REQ-029 values and validOut stays 0 until new pushes arrive; the first grant goes to lane 0.
REQ-037 Scenario, push on full with pop: lane 0 is full, pause=0 and lane 0 is granted while validIn0=1 -> the push is accepted, count0 stays 4 and err0 stays 0.

Source files
------------

// File: rtl/lane_arbiter.sv
// Four-lane byte arbiter: each lane buffers up to four words in a small FIFO,
// and a round-robin scheduler issues one word per cycle to a registered output.
module lane_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk_1,
    input  logic              reset,
    input  logic [DATA_W-1:0] dataIn0,
    input  logic [DATA_W-1:0] dataIn1,
    input  logic [DATA_W-1:0] dataIn2,
    input  logic [DATA_W-1:0] dataIn3,
    input  logic              validIn0,
    input  logic              validIn1,
    input  logic              validIn2,
    input  logic              validIn3,
    input  logic              pause,
    output logic [DATA_W-1:0] dataOut,
    output logic              validOut,
    output logic [1:0]        grant,
    output logic              full0,
    output logic              full1,
    output logic              full2,
    output logic              full3,
    output logic              err0,
    output logic              err1,
    output logic              err2,
    output logic              err3
);

    localparam int         LANES = 4;
    localparam logic [2:0] DEPTH = 3'd4;

    logic [DATA_W-1:0] din [LANES];
    logic [LANES-1:0]  vin;

    logic [DATA_W-1:0] mem_q [LANES][LANES];
    logic [2:0]        cnt_q  [LANES];
    logic [2:0]        cnt_d  [LANES];
    logic [1:0]        wptr_q [LANES];
    logic [1:0]        wptr_d [LANES];
    logic [1:0]        rptr_q [LANES];
    logic [1:0]        rptr_d [LANES];
    logic [LANES-1:0]  err_q;
    logic [LANES-1:0]  err_d;
    logic [LANES-1:0]  push;
    logic [LANES-1:0]  pop;

    logic [1:0]        last_q;
    logic [1:0]        last_d;
    logic [1:0]        grant_q;
    logic [1:0]        grant_d;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;
    logic              vout_q;
    logic              vout_d;

    logic              sel_vld;
    logic [1:0]        sel_lane;
    logic [1:0]        cand;

    assign din[0] = dataIn0;
    assign din[1] = dataIn1;
    assign din[2] = dataIn2;
    assign din[3] = dataIn3;
    assign vin    = {validIn3, validIn2, validIn1, validIn0};

    // Round-robin search starting just after the last granted lane, on pre-edge counts.
    always_comb begin
        sel_vld  = 1'b0;
        sel_lane = last_q;
        cand     = last_q;
        for (int k = 1; k <= LANES; k++) begin
            cand = last_q + 2'(k);
            if (!sel_vld && (cnt_q[cand] != 3'd0)) begin
                sel_vld  = 1'b1;
                sel_lane = cand;
            end
        end
        if (pause) begin
            sel_vld = 1'b0;
        end
    end

    // A full lane still accepts a push when it is popped on the same edge.
    always_comb begin
        push  = '0;
        pop   = '0;
        err_d = err_q;
        for (int l = 0; l < LANES; l++) begin
            pop[l]    = sel_vld && (sel_lane == 2'(l));
            push[l]   = vin[l] && ((cnt_q[l] != DEPTH) || pop[l]);
            err_d[l]  = err_q[l] | (vin[l] & ~push[l]);
            wptr_d[l] = push[l] ? wptr_q[l] + 2'd1 : wptr_q[l];
            rptr_d[l] = pop[l]  ? rptr_q[l] + 2'd1 : rptr_q[l];
            cnt_d[l]  = cnt_q[l];
            if (push[l] && !pop[l]) begin
                cnt_d[l] = cnt_q[l] + 3'd1;
            end else if (pop[l] && !push[l]) begin
                cnt_d[l] = cnt_q[l] - 3'd1;
            end
        end
    end

    always_comb begin
        dout_d  = dout_q;
        grant_d = grant_q;
        last_d  = last_q;
        vout_d  = 1'b0;
        if (sel_vld) begin
            dout_d  = mem_q[sel_lane][rptr_q[sel_lane]];
            grant_d = sel_lane;
            last_d  = sel_lane;
            vout_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_1) begin
        if (reset) begin
            for (int l = 0; l < LANES; l++) begin
                cnt_q[l]  <= 3'd0;
                wptr_q[l] <= 2'd0;
                rptr_q[l] <= 2'd0;
            end
            err_q   <= '0;
            last_q  <= 2'd3;
            grant_q <= 2'd0;
            dout_q  <= '0;
            vout_q  <= 1'b0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                cnt_q[l]  <= cnt_d[l];
                wptr_q[l] <= wptr_d[l];
                rptr_q[l] <= rptr_d[l];
            end
            err_q   <= err_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            dout_q  <= dout_d;
            vout_q  <= vout_d;
        end
    end

    // Storage carries no reset; the counts alone decide what is valid.
    always_ff @(posedge clk_1) begin
        for (int l = 0; l < LANES; l++) begin
            if (!reset && push[l]) begin
                mem_q[l][wptr_q[l]] <= din[l];
            end
        end
    end

    assign dataOut  = dout_q;
    assign validOut = vout_q;
    assign grant    = grant_q;
    assign full0    = (cnt_q[0] == DEPTH);
    assign full1    = (cnt_q[1] == DEPTH);
    assign full2    = (cnt_q[2] == DEPTH);
    assign full3    = (cnt_q[3] == DEPTH);
    assign err0     = err_q[0];
    assign err1     = err_q[1];
    assign err2     = err_q[2];
    assign err3     = err_q[3];

endmodule
